pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline boundary register for the 5-stage MIPS core. It generalises the decode/execute separator and is reused between any two stages: ID/EX, EX/MEM, MEM/WB. It carries an instruction payload with configurable field widths and takes its stall bits from the ctrl stop vector. It adds a flush input, a valid bit and write-enable qualification, and optionally saturating stall/bubble performance counters.

Parameters:
DATA_W, 32, width of num1/num2 operand fields
OP_W, 8, width of op field
SEL_W, 3, width of sel (result-select) field
ADDR_W, 5, destination register address width
STOP_W, 6, width of ctrl stop vector
STAGE_IDX, 2, index of this boundary's upstream stop bit; must satisfy STAGE_IDX+1 < STOP_W
OP_NOP, 8'h00, op value driven on bubble/flush/reset
SEL_NOP, 3'b000, sel value driven on bubble/flush/reset
CNT_W, 16, performance counter width (PERF_CNT_EN only)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
stop  in  STOP_W  stall vector from ctrl; bit=1 means stall, bit=0 means no stall
flush  in  1  kill contents (exception/branch redirect); synchronous
valid_i  in  1  upstream slot holds a real instruction
op_i  in  OP_W  opcode
sel_i  in  SEL_W  result select
num1_i  in  DATA_W  operand 1
num2_i  in  DATA_W  operand 2
desReg_addr_i  in  ADDR_W  destination register
en_wd_i  in  1  register write enable
valid_o  out  1  registered valid
op_o  out  OP_W  registered op
sel_o  out  SEL_W  registered sel
num1_o  out  DATA_W  registered operand 1
num2_o  out  DATA_W  registered operand 2
desReg_addr_o  out  ADDR_W  registered destination
en_wd_o  out  1  registered write enable, qualified by valid
stall_cnt  out  CNT_W  held-cycle count (PERF_CNT_EN only)
bubble_cnt  out  CNT_W  bubble-insert count (PERF_CNT_EN only)

Behaviour:
- Let up = stop[STAGE_IDX] and dn = stop[STAGE_IDX+1]. Evaluate on each rising clk, first match wins:
  1. rst=1: valid_o=0, op_o=OP_NOP, sel_o=SEL_NOP, num1_o=num2_o=0, desReg_addr_o=0, en_wd_o=0; counters cleared to 0.
  2. flush=1: outputs take the same values as reset; counters unchanged. flush overrides any stall.
  3. up=1, dn=0 (BUBBLE): outputs take the reset values; bubble_cnt increments.
  4. up=1, dn=1 (HOLD): all outputs keep their value; stall_cnt increments.
  5. up=0 (LOAD): all fields copied from the *_i inputs; valid_o=valid_i; en_wd_o = en_wd_i & valid_i.
- Latency is one cycle from input to output on LOAD. There is no combinational path from input to output.
- up=0 with dn=1 is illegal from ctrl. It is handled as LOAD, with no assertion in RTL.
- The stop bits of other stages are ignored.
- A HOLD that lasts N cycles followed by LOAD presents the held payload for exactly N+1 cycles in total.
- flush during HOLD discards the held instruction in the same edge.
- Counters saturate at all-ones and never wrap.
- rst arriving mid-stall clears everything at the next edge. The stall/flush/bubble state resumes only on the edge after rst deasserts.

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined: stall_cnt and bubble_cnt ports exist and count as described in Behaviour.
- Undefined: both ports and counters are removed and the payload behaviour is identical.
- The bench checks the counters only when the macro is defined.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> every output is 0/NOP, valid_o=0; counters=0.
- Load: stop=0, valid_i=1, op_i=8'h21, num1_i=32'h1234_5678, desReg_addr_i=5'd9, en_wd_i=1 -> the next cycle shows the same values, valid_o=1, en_wd_o=1. Repeat with valid_i=0, en_wd_i=1 -> en_wd_o=0.
- Hold: load op=8'h21, then stop=6'b001100 for 3 cycles while inputs change -> outputs stay at op=8'h21 for 4 cycles; stall_cnt=3.
- Bubble: stop=6'b000100 for 1 cycle -> op_o=OP_NOP, valid_o=0, en_wd_o=0; bubble_cnt=1. stop=0 next cycle -> new input loaded.
- Flush priority: flush=1 with stop=6'b001100 while holding valid data -> the next cycle outputs are NOP/0; counters unchanged.
- Saturation with CNT_W=4: hold for 20 cycles -> stall_cnt=4'hF and stays there.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Payload bundle carried across one pipeline boundary (valid, op, sel, operands, destination, write enable).
// The driving side uses the master modport; the receiving side uses slave.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 8,
    parameter int SEL_W  = 3,
    parameter int ADDR_W = 5
);
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] num1;
    logic [DATA_W-1:0] num2;
    logic [ADDR_W-1:0] desReg_addr;
    logic              en_wd;

    modport master (output valid, op, sel, num1, num2, desReg_addr, en_wd);
    modport slave  (input  valid, op, sel, num1, num2, desReg_addr, en_wd);
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register (ID/EX, EX/MEM, MEM/WB) with flush, bubble and hold.
// Optional saturating stall/bubble counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_reg #(
    parameter int               DATA_W    = 32,
    parameter int               OP_W      = 8,
    parameter int               SEL_W     = 3,
    parameter int               ADDR_W    = 5,
    parameter int               STOP_W    = 6,
    parameter int               STAGE_IDX = 2,
    parameter logic [OP_W-1:0]  OP_NOP    = 8'h00,
    parameter logic [SEL_W-1:0] SEL_NOP   = 3'b000,
    parameter int               CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STOP_W-1:0] stop,
    input  logic              flush,
    pipe_stage_reg_if.slave   up_i,
    pipe_stage_reg_if.master  dn_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] num1;
        logic [DATA_W-1:0] num2;
        logic [ADDR_W-1:0] desReg_addr;
        logic              en_wd;
    } payload_t;

    logic     up, dn;
    logic     do_bubble, do_hold;
    logic     unused_stop;
    payload_t nop_c, load_c, pl_d, pl_q;

    assign up          = stop[STAGE_IDX];
    assign dn          = stop[STAGE_IDX+1];
    // Only two stop bits matter here; the rest belong to other boundaries.
    assign unused_stop = ^stop;
    assign do_bubble   = !flush && up && !dn;
    assign do_hold     = !flush && up && dn;

    always_comb begin
        nop_c             = '0;
        nop_c.op          = OP_NOP;
        nop_c.sel         = SEL_NOP;

        load_c.valid       = up_i.valid;
        load_c.op          = up_i.op;
        load_c.sel         = up_i.sel;
        load_c.num1        = up_i.num1;
        load_c.num2        = up_i.num2;
        load_c.desReg_addr = up_i.desReg_addr;
        load_c.en_wd       = up_i.en_wd & up_i.valid;
    end

    // up=0 always loads, including the dn=1 combination ctrl never produces.
    always_comb begin
        pl_d = load_c;
        if (flush || do_bubble) pl_d = nop_c;
        else if (do_hold)       pl_d = pl_q;
    end

    always_ff @(posedge clk) begin
        if (rst) pl_q <= nop_c;
        else     pl_q <= pl_d;
    end

    assign dn_o.valid       = pl_q.valid;
    assign dn_o.op          = pl_q.op;
    assign dn_o.sel         = pl_q.sel;
    assign dn_o.num1        = pl_q.num1;
    assign dn_o.num2        = pl_q.num2;
    assign dn_o.desReg_addr = pl_q.desReg_addr;
    assign dn_o.en_wd       = pl_q.en_wd;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (do_hold && stall_cnt_q != '1)     stall_cnt_d  = stall_cnt_q + CNT_W'(1);
        if (do_bubble && bubble_cnt_q != '1)  bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps from the test plan, then randomized traffic
// against a rule-level reference model. Counter checks are active with PIPE_PERF_CNT_EN.
module tb_pipe_stage_reg;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 8;
    localparam int SEL_W   = 3;
    localparam int ADDR_W  = 5;
    localparam int STOP_W  = 6;
    localparam int STG     = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic [STOP_W-1:0] stop;
    logic flush;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .OP_W(OP_W), .SEL_W(SEL_W), .ADDR_W(ADDR_W)) up_if ();
    pipe_stage_reg_if #(.DATA_W(DATA_W), .OP_W(OP_W), .SEL_W(SEL_W), .ADDR_W(ADDR_W)) dn_if ();

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W(DATA_W), .OP_W(OP_W), .SEL_W(SEL_W), .ADDR_W(ADDR_W),
        .STOP_W(STOP_W), .STAGE_IDX(STG), .OP_NOP(8'h00), .SEL_NOP(3'b000),
        .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .stop  (stop),
        .flush (flush),
        .up_i  (up_if.slave),
        .dn_o  (dn_if.master)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    // ---------------- reference model ----------------
    logic              m_valid;
    logic [OP_W-1:0]   m_op;
    logic [SEL_W-1:0]  m_sel;
    logic [DATA_W-1:0] m_num1, m_num2;
    logic [ADDR_W-1:0] m_addr;
    logic              m_wd;
    int                m_stall, m_bubble;

    int vectors     = 0;
    int miscompares = 0;

    task automatic model_clear();
        m_valid = 1'b0; m_op = 8'h00; m_sel = 3'b000;
        m_num1 = '0; m_num2 = '0; m_addr = '0; m_wd = 1'b0;
    endtask

    // Applies the boundary rules for the inputs sampled at this edge.
    task automatic model_step();
        if (rst) begin
            model_clear();
            m_stall = 0; m_bubble = 0;
        end else if (flush) begin
            model_clear();
        end else if (stop[STG] && !stop[STG+1]) begin
            model_clear();
            if (m_bubble < CNT_MAX) m_bubble++;
        end else if (stop[STG] && stop[STG+1]) begin
            if (m_stall < CNT_MAX) m_stall++;
        end else begin
            m_valid = up_if.valid; m_op = up_if.op; m_sel = up_if.sel;
            m_num1 = up_if.num1; m_num2 = up_if.num2; m_addr = up_if.desReg_addr;
            m_wd = up_if.en_wd && up_if.valid;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", 64'(dn_if.valid), 64'(m_valid));
        chk("op",    64'(dn_if.op),    64'(m_op));
        chk("sel",   64'(dn_if.sel),   64'(m_sel));
        chk("num1",  64'(dn_if.num1),  64'(m_num1));
        chk("num2",  64'(dn_if.num2),  64'(m_num2));
        chk("addr",  64'(dn_if.desReg_addr), 64'(m_addr));
        chk("en_wd", 64'(dn_if.en_wd), 64'(m_wd));
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt",  64'(stall_cnt),  64'(m_stall));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`endif
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic v, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] n1,
                         input logic [ADDR_W-1:0] a, input logic wd);
        up_if.valid = v; up_if.op = op; up_if.sel = SEL_W'($urandom_range(0, 7));
        up_if.num1 = n1; up_if.num2 = $urandom; up_if.desReg_addr = a; up_if.en_wd = wd;
    endtask

    task automatic drive_rand();
        drive(1'($urandom), OP_W'($urandom), $urandom, ADDR_W'($urandom), 1'($urandom));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        m_stall = 0; m_bubble = 0;
        model_clear();
        rst = 1'b1; flush = 1'b0; stop = STOP_W'($urandom);
        drive_rand();

        // Reset with random inputs
        cycle();
        drive_rand(); stop = STOP_W'($urandom); flush = 1'($urandom);
        cycle();
        chk("rst_valid", 64'(dn_if.valid), 64'(0));
        chk("rst_op", 64'(dn_if.op), 64'(8'h00));
        rst = 1'b0; flush = 1'b0;

        // Load valid instruction, then invalid one with en_wd set
        stop = '0;
        drive(1'b1, 8'h21, 32'h1234_5678, 5'd9, 1'b1);
        cycle();
        chk("load_op",   64'(dn_if.op),   64'(8'h21));
        chk("load_num1", 64'(dn_if.num1), 64'(32'h1234_5678));
        chk("load_addr", 64'(dn_if.desReg_addr), 64'(5'd9));
        chk("load_wd",   64'(dn_if.en_wd), 64'(1));
        drive(1'b0, 8'h22, 32'h0, 5'd3, 1'b1);
        cycle();
        chk("inv_wd", 64'(dn_if.en_wd), 64'(0));

        // Hold for 3 cycles: payload visible for 4 cycles total
        drive(1'b1, 8'h21, 32'hCAFE_0001, 5'd7, 1'b1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            stop = 6'b001100;
            drive_rand();
            cycle();
            chk("hold_op", 64'(dn_if.op), 64'(8'h21));
        end
`ifdef PIPE_PERF_CNT_EN
        chk("hold_stall3", 64'(stall_cnt), 64'(3));
`endif

        // Bubble, then load
        stop = 6'b000100; drive_rand();
        cycle();
        chk("bub_op", 64'(dn_if.op), 64'(8'h00));
        chk("bub_valid", 64'(dn_if.valid), 64'(0));
`ifdef PIPE_PERF_CNT_EN
        chk("bub_cnt1", 64'(bubble_cnt), 64'(1));
`endif
        stop = '0; drive(1'b1, 8'h5A, 32'hBEEF_0002, 5'd4, 1'b1);
        cycle();
        chk("after_bub_op", 64'(dn_if.op), 64'(8'h5A));

        // Flush beats hold
        stop = 6'b001100; drive_rand();
        cycle();
        flush = 1'b1; drive_rand();
        cycle();
        chk("flush_valid", 64'(dn_if.valid), 64'(0));
        chk("flush_op", 64'(dn_if.op), 64'(8'h00));
        flush = 1'b0;

        // Randomized traffic, other stop bits toggling freely
        for (int i = 0; i < 400; i++) begin
            drive_rand();
            stop  = STOP_W'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0; flush = 1'b0;

        // Counter saturation with a long hold
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            stop = 6'b001100; drive_rand();
            cycle();
        end
`ifdef PIPE_PERF_CNT_EN
        chk("stall_sat", 64'(stall_cnt), 64'(4'hF));
`endif
        stop = '0; drive_rand();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
